// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared types, defaults and helpers for the APB master controller
// Contents: FSM state enum, default bus widths, response record, one-hot select decode.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERRRSP = 2'd3
    } apb_state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int MAX_SLAVES = 16;

    // Sized for the widest legal data bus; narrower builds use the low bits.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

    function automatic logic [MAX_SLAVES-1:0] onehot_dec(input int unsigned idx);
        onehot_dec = '0;
        if (idx < MAX_SLAVES) begin
            onehot_dec[idx[3:0]] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/apb_master_ctrl_param_if.sv
// rtl/apb_master_ctrl_param_if.sv - request/response handshake plus APB bus bundle
// Signals: req_valid/req_ready/req_write/req_addr/req_wdata/req_sel (request),
//          rsp_valid/rsp_rdata/rsp_err (response pulse),
//          Paddr/Pwdata/Pwrite/Penable/Pselx/Prdata/Pready/Pslverr (APB).
// Modports: master = controller view, slave = front end plus muxed peripherals.
interface apb_master_ctrl_param_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 3,
    parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [SEL_W-1:0]  req_sel;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0]     Paddr;
    logic [DATA_W-1:0]     Pwdata;
    logic                  Pwrite;
    logic                  Penable;
    logic [NUM_SLAVES-1:0] Pselx;
    logic [DATA_W-1:0]     Prdata;
    logic                  Pready;
    logic                  Pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_sel,
        input  Prdata, Pready, Pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output Paddr, Pwdata, Pwrite, Penable, Pselx
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_sel,
        output Prdata, Pready, Pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  Paddr, Pwdata, Pwrite, Penable, Pselx
    );

endinterface

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - 8-bit wait-state counter with limit compare
// Ports: clk_i, rst_ni (async active-low), clear_i (restart count), inc_i (count one
//        wait cycle), expired_o (count has reached LIMIT).
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 8'(LIMIT));

endmodule

// File: rtl/apb_master_ctrl_param.sv
// rtl/apb_master_ctrl_param.sv - parametrised APB master controller (SETUP/ACCESS sequencer)
// Ports: Hclk, Hresetn (async active-low), bus (apb_master_ctrl_param_if.master:
//        request handshake, one-cycle response pulse, APB master signals).
// Optional: APB_TIMEOUT_EN adds a wait-state timeout (TIMEOUT_CYCLES) via apb_wait_timer.
module apb_master_ctrl_param
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int NUM_SLAVES     = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    Hclk,
    input  logic                    Hresetn,
    apb_master_ctrl_param_if.master bus
);

    apb_state_t            state_q, state_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    apb_rsp_t              rsp_q, rsp_d;

    logic                  req_ready;
    logic                  accept;
    logic                  sel_ok;
    logic                  timeout_hit;
    logic [MAX_SLAVES-1:0] sel_dec;

    // A completing ACCESS can take the next request so transfers chain SETUP/ACCESS.
    assign req_ready = (state_q == IDLE) || ((state_q == ACCESS) && bus.Pready);
    assign accept    = bus.req_valid && req_ready;
    assign sel_ok    = int'(bus.req_sel) < NUM_SLAVES;
    assign sel_dec   = onehot_dec(int'(bus.req_sel));

`ifdef APB_TIMEOUT_EN
    logic timer_expired;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i     (Hclk),
        .rst_ni    (Hresetn),
        .clear_i   (state_q == SETUP),
        .inc_i     ((state_q == ACCESS) && !bus.Pready),
        .expired_o (timer_expired)
    );

    // Pready in the limit cycle still completes normally.
    assign timeout_hit = timer_expired && !bus.Pready;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_d       = rsp_q;

        case (state_q)
            IDLE: begin
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.Pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_d.err   = bus.Pslverr;
                    rsp_d.rdata = '0;
                    if (!pwrite_q && !bus.Pslverr) begin
                        rsp_d.rdata[DATA_W-1:0] = bus.Prdata;
                    end
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end else if (timeout_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_d.err   = 1'b1;
                    rsp_d.rdata = '0;
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                end
            end
            ERRRSP: begin
                rsp_valid_d = 1'b1;
                rsp_d.err   = 1'b1;
                rsp_d.rdata = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // accept is only possible from IDLE or a completing ACCESS, so it overrides both.
        if (accept) begin
            penable_d = 1'b0;
            if (sel_ok) begin
                state_d  = SETUP;
                psel_d   = sel_dec[NUM_SLAVES-1:0];
                paddr_d  = bus.req_addr;
                pwdata_d = bus.req_wdata;
                pwrite_d = bus.req_write;
            end else begin
                state_d = ERRRSP;
                psel_d  = '0;
            end
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.Pselx     = psel_q;
    assign bus.Penable   = penable_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_q.rdata[DATA_W-1:0];
    assign bus.rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_apb_master_ctrl_param.sv
// tb/tb_apb_master_ctrl_param.sv - self-checking bench for apb_master_ctrl_param
module tb_apb_master_ctrl_param;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int NUM_SLAVES     = 3;
    localparam int TIMEOUT_CYCLES = 4;

    logic Hclk;
    logic Hresetn;
    int   checks = 0;
    int   errors = 0;

    apb_master_ctrl_param_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES)
    ) bus ();

    apb_master_ctrl_param #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    typedef struct {
        int          lat;
        int          pulses;
        int          acc;
        logic [31:0] rdata;
        logic        err;
        logic [2:0]  psel1;
        logic        pen1;
        logic [31:0] paddr1;
        logic [31:0] pwdata1;
        logic        pwrite1;
        bit          unstable;
        bit          anysel;
        logic        rdy;
    } obs_t;

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    // Transaction-level reference: what the response should be for one request.
    function automatic void ref_rsp(input bit wr, input int sel, input logic [31:0] prd,
                                    input bit serr, output logic [31:0] rd, output logic err);
        err = (sel >= NUM_SLAVES) || serr;
        rd  = (!wr && !err) ? prd : 32'h0;
    endfunction

    function automatic int ref_lat(input int sel, input int waits);
        return (sel >= NUM_SLAVES) ? 2 : 3 + waits;
    endfunction

    // Issues one request from idle, plays the slave with 'waits' wait states and records
    // what happened on the bus; cycle numbers count from the accepting edge.
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int sel, input int waits, input logic [31:0] prd,
                           input bit serr, output obs_t o);
        int ncyc;
        o.lat = -1; o.pulses = 0; o.acc = 0; o.rdata = '0; o.err = 1'b0;
        o.unstable = 1'b0; o.anysel = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_sel   = sel[1:0];
        bus.Prdata    = prd;
        bus.Pslverr   = serr;
        bus.Pready    = 1'b0;
        o.rdy = bus.req_ready;
        tick();
        bus.req_valid = 1'b0;
        o.psel1   = bus.Pselx;
        o.pen1    = bus.Penable;
        o.paddr1  = bus.Paddr;
        o.pwdata1 = bus.Pwdata;
        o.pwrite1 = bus.Pwrite;
        o.anysel  = (bus.Pselx != 0);
        ncyc = 3 + ((waits > 20) ? 20 : waits) + 5;
        for (int c = 2; c <= ncyc; c++) begin
            tick();
            if (bus.Pselx != 0) o.anysel = 1'b1;
            if (bus.rsp_valid) begin
                if (o.lat < 0) begin
                    o.lat   = c;
                    o.rdata = bus.rsp_rdata;
                    o.err   = bus.rsp_err;
                end
                o.pulses++;
            end
            if (bus.Penable) begin
                o.acc++;
                if (bus.Pselx !== o.psel1 || bus.Paddr !== o.paddr1 ||
                    bus.Pwdata !== o.pwdata1 || bus.Pwrite !== o.pwrite1) o.unstable = 1'b1;
                bus.Pready = (o.acc > waits);
            end else begin
                bus.Pready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (bus.Pselx !== 3'b000 || bus.Penable !== 1'b0 || bus.Pwrite !== 1'b0 ||
            bus.Paddr !== 32'h0 || bus.Pwdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_apb: Pselx=%b Penable=%b Pwrite=%b Paddr=%h Pwdata=%h want all 0",
                     bus.Pselx, bus.Penable, bus.Pwrite, bus.Paddr, bus.Pwdata);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b rdata=%h err=%b want 0", bus.rsp_valid,
                     bus.rsp_rdata, bus.rsp_err);
        end
        Hresetn = 1'b1;
        tick();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_single_write();
        obs_t o;
        do_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 0, 32'hA5A5_A5A5, 1'b0, o);
        checks++;
        if (o.rdy !== 1'b1 || o.psel1 !== 3'b010 || o.pen1 !== 1'b0) begin
            errors++;
            $display("FAIL single_write_setup: rdy=%b psel=%b pen=%b want 1 010 0", o.rdy, o.psel1, o.pen1);
        end
        checks++;
        if (o.paddr1 !== 32'h10 || o.pwdata1 !== 32'hDEAD_BEEF || o.pwrite1 !== 1'b1) begin
            errors++;
            $display("FAIL single_write_bus: addr=%h wdata=%h wr=%b want 00000010 deadbeef 1",
                     o.paddr1, o.pwdata1, o.pwrite1);
        end
        checks++;
        if (o.acc !== 1 || o.lat !== 3 || o.pulses !== 1) begin
            errors++;
            $display("FAIL single_write_timing: acc=%0d lat=%0d pulses=%0d want 1 3 1", o.acc, o.lat, o.pulses);
        end
        checks++;
        if (o.err !== 1'b0 || o.rdata !== 32'h0) begin
            errors++;
            $display("FAIL single_write_rsp: err=%b rdata=%h want 0 0", o.err, o.rdata);
        end
    endtask

    task automatic test_read_wait();
        obs_t o;
        do_xfer(1'b0, 32'h0000_0020, 32'h0, 2, 3, 32'h1234_5678, 1'b0, o);
        checks++;
        if (o.psel1 !== 3'b100 || o.acc !== 4 || o.unstable) begin
            errors++;
            $display("FAIL read_wait_apb: psel=%b acc=%0d unstable=%0d want 100 4 0", o.psel1, o.acc, o.unstable);
        end
        checks++;
        if (o.lat !== 6 || o.err !== 1'b0 || o.rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL read_wait_rsp: lat=%0d err=%b rdata=%h want 6 0 12345678", o.lat, o.err, o.rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  pen;
        logic [2:0]  ps1, ps3;
        int          rsp_at[$];
        logic [31:0] rsp_rd[$];
        bus.Pready    = 1'b1;
        bus.Pslverr   = 1'b0;
        bus.Prdata    = 32'hCAFE_0001;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_0100;
        bus.req_wdata = 32'h0000_0011;
        bus.req_sel   = 2'd0;
        pen = '0;
        ps3 = '0;
        tick();
        pen[0] = bus.Penable;
        ps1    = bus.Pselx;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_0200;
        bus.req_sel   = 2'd1;
        for (int c = 2; c <= 8; c++) begin
            tick();
            if (c == 3) begin
                bus.req_valid = 1'b0;
                ps3 = bus.Pselx;
            end
            if (c <= 4) pen[c-1] = bus.Penable;
            if (bus.rsp_valid) begin
                rsp_at.push_back(c);
                rsp_rd.push_back(bus.rsp_rdata);
            end
        end
        bus.Pready = 1'b0;
        checks++;
        if (pen !== 4'b1010 || ps1 !== 3'b001 || ps3 !== 3'b010) begin
            errors++;
            $display("FAIL b2b_apb: penable(T1..T4 lsb first)=%b psel1=%b psel3=%b want 1010 001 010", pen, ps1, ps3);
        end
        checks++;
        if (rsp_at.size() != 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d pulses want 2", rsp_at.size());
        end else if (rsp_at[0] != 3 || rsp_at[1] != 5 || rsp_rd[0] !== 32'h0 || rsp_rd[1] !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL b2b_rsp: at %0d,%0d rdata %h,%h want 3,5 00000000,cafe0001",
                     rsp_at[0], rsp_at[1], rsp_rd[0], rsp_rd[1]);
        end
    endtask

    task automatic test_slverr();
        obs_t o;
        do_xfer(1'b0, 32'h0000_0044, 32'h0, 0, 1, 32'h5555_AAAA, 1'b1, o);
        checks++;
        if (o.lat !== 4 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
            errors++;
            $display("FAIL slverr_rsp: lat=%0d err=%b rdata=%h want 4 1 0", o.lat, o.err, o.rdata);
        end
        checks++;
        if (bus.rsp_err !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL slverr_hold: err=%b valid=%b want 1 0", bus.rsp_err, bus.rsp_valid);
        end
    endtask

    task automatic test_bad_sel();
        obs_t o;
        do_xfer(1'b0, 32'h0000_0050, 32'h0, 3, 0, 32'h7777_7777, 1'b0, o);
        checks++;
        if (o.anysel || o.acc !== 0) begin
            errors++;
            $display("FAIL bad_sel_apb: anysel=%0d acc=%0d want 0 0", o.anysel, o.acc);
        end
        checks++;
        if (o.lat !== 2 || o.pulses !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
            errors++;
            $display("FAIL bad_sel_rsp: lat=%0d pulses=%0d err=%b rdata=%h want 2 1 1 0",
                     o.lat, o.pulses, o.err, o.rdata);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_0300;
        bus.req_wdata = 32'h0BAD_0BAD;
        bus.req_sel   = 2'd2;
        bus.Pready    = 1'b0;
        bus.Pslverr   = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        checks++;
        if (bus.Penable !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: Penable=%b want 1", bus.Penable);
        end
        Hresetn = 1'b0;
        #2;
        checks++;
        if (bus.Pselx !== 3'b000 || bus.Penable !== 1'b0 || bus.Paddr !== 32'h0 ||
            bus.Pwdata !== 32'h0 || bus.Pwrite !== 1'b0 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_async: Pselx=%b Penable=%b Paddr=%h rsp_valid=%b rsp_err=%b want 0",
                     bus.Pselx, bus.Penable, bus.Paddr, bus.rsp_valid, bus.rsp_err);
        end
        tick();
        tick();
        Hresetn    = 1'b1;
        bus.Pready = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.rsp_valid !== 1'b0 || bus.Pselx !== 3'b000) bad++;
        end
        bus.Pready = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_after: %0d cycles with activity want 0", bad);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        bit          wr, serr;
        int          sel, waits;
        logic [31:0] addr, wdata, prd, e_rd;
        logic        e_err;
        for (int n = 0; n < 24; n++) begin
            wr    = 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = $urandom;
            sel   = $urandom_range(0, 3);
            waits = $urandom_range(0, 3);
            prd   = $urandom;
            serr  = ($urandom_range(0, 3) == 0);
            do_xfer(wr, addr, wdata, sel, waits, prd, serr, o);
            ref_rsp(wr, sel, prd, serr, e_rd, e_err);
            checks++;
            if (o.lat !== ref_lat(sel, waits) || o.pulses !== 1) begin
                errors++;
                $display("FAIL rand%0d_timing: lat=%0d pulses=%0d want %0d 1", n, o.lat, o.pulses, ref_lat(sel, waits));
            end
            checks++;
            if (o.err !== e_err || o.rdata !== e_rd) begin
                errors++;
                $display("FAIL rand%0d_rsp: err=%b rdata=%h want %b %h", n, o.err, o.rdata, e_err, e_rd);
            end
            checks++;
            if (sel < NUM_SLAVES) begin
                if (o.psel1 !== 3'(1 << sel) || o.pen1 !== 1'b0 || o.paddr1 !== addr ||
                    o.pwdata1 !== wdata || o.pwrite1 !== wr || o.acc !== waits + 1 || o.unstable) begin
                    errors++;
                    $display("FAIL rand%0d_apb: psel=%b addr=%h wdata=%h wr=%b acc=%0d want %b %h %h %b %0d",
                             n, o.psel1, o.paddr1, o.pwdata1, o.pwrite1, o.acc, 3'(1 << sel), addr, wdata, wr, waits + 1);
                end
            end else if (o.anysel || o.acc !== 0) begin
                errors++;
                $display("FAIL rand%0d_badsel: anysel=%0d acc=%0d want 0 0", n, o.anysel, o.acc);
            end
        end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        do_xfer(1'b0, 32'h0000_0060, 32'h0, 1, 100, 32'h1357_9BDF, 1'b0, o);
        checks++;
        if (o.acc !== TIMEOUT_CYCLES + 1 || o.lat !== TIMEOUT_CYCLES + 3 || o.pulses !== 1) begin
            errors++;
            $display("FAIL timeout_timing: acc=%0d lat=%0d pulses=%0d want %0d %0d 1",
                     o.acc, o.lat, o.pulses, TIMEOUT_CYCLES + 1, TIMEOUT_CYCLES + 3);
        end
        checks++;
        if (o.err !== 1'b1 || o.rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_rsp: err=%b rdata=%h want 1 0", o.err, o.rdata);
        end
        do_xfer(1'b0, 32'h0000_0064, 32'h0, 1, 0, 32'h2468_ACE0, 1'b0, o);
        checks++;
        if (o.rdy !== 1'b1 || o.lat !== 3 || o.err !== 1'b0 || o.rdata !== 32'h2468_ACE0) begin
            errors++;
            $display("FAIL timeout_next: rdy=%b lat=%0d err=%b rdata=%h want 1 3 0 2468ace0",
                     o.rdy, o.lat, o.err, o.rdata);
        end
    endtask
`endif

    initial begin
        Hresetn       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_sel   = '0;
        bus.Prdata    = '0;
        bus.Pready    = 1'b0;
        bus.Pslverr   = 1'b0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_slverr();
        test_bad_sel();
        test_reset_mid();
        test_random();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl_param.md
Name: apb_master_ctrl_param

Overview:
Parametrised APB master controller for the next-generation AHB-to-APB bridge. Accepts one transfer request at a time from the AHB-side front end over a valid/ready handshake and runs the APB SETUP/ACCESS sequence on one of NUM_SLAVES peripherals. Honours Pready wait states and Pslverr, then returns read data and error status as a one-cycle response pulse. Adds configurable widths, slave count, back-to-back transfers and error reporting.

Parameters:
ADDR_W, 32, width of request address and Paddr
DATA_W, 32, width of wdata/rdata/Pwdata/Prdata; must be 8, 16 or 32
NUM_SLAVES, 3, number of APB slaves; width of Pselx; range 1..16
TIMEOUT_CYCLES, 16, wait-state limit; used only when APB_TIMEOUT_EN is defined; range 1..255
SEL_W (localparam), max(1, clog2(NUM_SLAVES)), width of req_sel

Ports:
Hclk  in  1  clock; all logic on the rising edge
Hresetn  in  1  asynchronous active-low reset
req_valid  in  1  transfer request valid
req_ready  out  1  controller can accept a request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  transfer address
req_wdata  in  DATA_W  write data
req_sel  in  SEL_W  binary slave index
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  transfer ended in error
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Pwrite  out  1  APB direction
Penable  out  1  APB enable
Pselx  out  NUM_SLAVES  one-hot APB select
Prdata  in  DATA_W  read data from the muxed slave
Pready  in  1  slave ready from the muxed slave
Pslverr  in  1  slave error from the muxed slave

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer): state IDLE; Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. No response is produced for an aborted transfer.
- All outputs are registered except req_ready, which decodes state and Pready.
- States: IDLE, SETUP, ACCESS, ERRRSP.
- req_ready = (state==IDLE) or (state==ACCESS and Pready).
- Accept = req_valid & req_ready at a rising edge. The controller latches addr, wdata, write and sel.
- On accept with req_sel < NUM_SLAVES:
  - go to SETUP.
  - Pselx = one-hot(sel), Penable=0.
  - Paddr, Pwdata and Pwrite take the latched values.
- On accept with req_sel >= NUM_SLAVES:
  - go to ERRRSP; no APB activity.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0; then go to IDLE.
- SETUP -> ACCESS unconditionally; Penable=1.
- ACCESS with Pready=0: hold all APB outputs stable (wait state).
- ACCESS with Pready=1 completes the transfer. In the next cycle:
  - rsp_valid=1 and rsp_err=Pslverr.
  - rsp_rdata = Prdata if the transfer was a read with Pslverr=0; otherwise 0.
- ACCESS exit in the completion cycle:
  - If a new request is accepted, go to SETUP with the new Pselx/Paddr and Penable=0.
  - Otherwise go to IDLE with Pselx=0 and Penable=0.
- Latency, zero wait states: accept at edge T → SETUP in cycle T+1, ACCESS in T+2, rsp_valid in T+3. Sustained throughput is one transfer per 2 cycles.
- Paddr, Pwdata and Pwrite hold their last values in IDLE.
- rsp_rdata and rsp_err hold their values after the rsp_valid pulse; rsp_valid lasts exactly 1 cycle.
- The response path has no backpressure; the consumer must accept rsp_valid.

Optional Feature:
Macro: APB_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with Pready=0.
  - When the count reaches TIMEOUT_CYCLES with Pready still 0, the transfer aborts: Pselx=0, Penable=0, state IDLE.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0. req_ready stays 0 in the abort cycle.
  - Pready=1 in the same cycle as the limit wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely for Pready.

Decomposition:
- Shared package ahb_apb_pkg:
  - state enum (IDLE, SETUP, ACCESS, ERRRSP).
  - default ADDR_W/DATA_W constants.
  - a one-hot decode function.
  - a response record type (rdata, err).
- One sub-module, apb_wait_timer: counter plus limit compare, instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Single write: addr 0x0000_0010, wdata 0xDEAD_BEEF, sel=1, Pready tied 1 → Pselx=3'b010 at T+1, Penable at T+2, rsp_valid at T+3 with err=0 and rdata=0.
- Read with 3 wait states: sel=2, Prdata=0x1234_5678, Pready low for 3 ACCESS cycles → APB outputs stable 4 ACCESS cycles; rsp_rdata=0x1234_5678, err=0.
- Back-to-back: write sel0 then read sel1, req_valid held, Pready=1 → second SETUP immediately after first ACCESS; Penable pattern 0,1,0,1; two rsp_valid pulses 2 cycles apart.
- Error paths:
  - Pslverr=1 on read completion → rsp_err=1, rdata=0.
  - req_sel=3 with NUM_SLAVES=3 → no Pselx activity; rsp_err=1 one cycle after accept.
- Reset mid-ACCESS: Hresetn low asynchronously while Penable=1 → all outputs 0 before the next edge; no rsp_valid after release.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, Pready stuck 0 → abort after 4 wait cycles; rsp_err=1; next request accepted normally.
